// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Synchronizes board switches/buttons; buttons become one-cycle
//            press strobes. Debounce built only with
//            INPUT_CONDITIONER_DEBOUNCE_EN defined.
// Revision : 1.0
// ============================================================================
module input_conditioner #(
  parameter int DATA_W     = 4,
  parameter int STB_N      = 2,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [STB_N-1:0]  btn_in,
  output logic [DATA_W-1:0] data_out,
  output logic [STB_N-1:0]  strobe_out
);

  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("input_conditioner: DEB_CYCLES must be >= 1");
  end

  logic [DATA_W-1:0] r_sw_meta;
  logic [DATA_W-1:0] r_sw_s;
  logic [DATA_W-1:0] r_data;
  logic [STB_N-1:0]  r_btn_meta;
  logic [STB_N-1:0]  r_btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_data     <= '0;
      r_btn_meta <= '0;
      r_btn_s    <= '0;
    end else begin
      r_sw_meta  <= sw_in;
      r_sw_s     <= r_sw_meta;
      r_data     <= r_sw_s;
      r_btn_meta <= btn_in;
      r_btn_s    <= r_btn_meta;
    end
  end

  assign data_out = r_data;

  for (genvar i = 0; i < STB_N; i++) begin : g_btn
    logic r_lvl;
    logic r_strobe;
    logic w_lvl_next;

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int c_cnt_w = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;

    // Any sample agreeing with the accepted level restarts the count.
    always_comb begin
      w_lvl_next = r_lvl;
      w_cnt_next = r_cnt;
      if (r_btn_s[i] == r_lvl) begin
        w_cnt_next = '0;
      end else if (r_cnt == c_cnt_max) begin
        w_lvl_next = r_btn_s[i];
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + c_cnt_one;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
`else
    assign w_lvl_next = r_btn_s[i];
`endif

    // Strobe is raised on the same edge the accepted level rises.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_lvl    <= 1'b0;
        r_strobe <= 1'b0;
      end else begin
        r_lvl    <= w_lvl_next;
        r_strobe <= w_lvl_next & ~r_lvl;
      end
    end

    assign strobe_out[i] = r_strobe;
  end

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Directed self-checking bench for input_conditioner (DEB_CYCLES=4),
//            expectations adapt to INPUT_CONDITIONER_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module tb_input_conditioner;

  localparam int DATA_W = 4;
  localparam int STB_N  = 2;
  localparam int DEB    = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int LAT = 1 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DEB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sw_in = '0;
  logic [STB_N-1:0]  btn_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [STB_N-1:0]  strobe_out;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .DATA_W    (DATA_W),
    .STB_N     (STB_N),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .data_out  (data_out),
    .strobe_out(strobe_out)
  );

  always #5 clk = ~clk;

  // Pass one rising edge and let outputs settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_in = '0;
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sw_in  = DATA_W'($urandom);
      btn_in = STB_N'($urandom);
      tick();
      checks++;
      if (data_out !== 4'b0000 || strobe_out !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold k=%0d data=%b strobe=%b exp data=0000 strobe=00", k, data_out, strobe_out);
      end
    end
    sw_in  = '0;
    btn_in = '0;
    rst    = 1'b0;
    tick();
    checks++;
    if (data_out !== 4'b0000 || strobe_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_release data=%b strobe=%b exp data=0000 strobe=00", data_out, strobe_out);
    end
    idle(12);
  endtask

  task automatic test_switch();
    logic [DATA_W-1:0] vals [2];
    logic [DATA_W-1:0] prev;
    vals[0] = 4'b0101;
    vals[1] = 4'b1100;
    prev = 4'b0000;
    for (int v = 0; v < 2; v++) begin
      sw_in = vals[v];
      tick();
      tick();
      checks++;
      if (data_out !== prev) begin
        errors++;
        $display("FAIL switch_early v=%0d got=%b exp=%b", v, data_out, prev);
      end
      tick();
      checks++;
      if (data_out !== vals[v]) begin
        errors++;
        $display("FAIL switch_latency v=%0d got=%b exp=%b", v, data_out, vals[v]);
      end
      prev = vals[v];
      tick();
    end
  endtask

  task automatic test_press();
    logic [STB_N-1:0] exp;
    btn_in = 2'b01;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) btn_in = 2'b00;
      tick();
      exp = (k == LAT) ? 2'b01 : 2'b00;
      checks++;
      if (strobe_out !== exp) begin
        errors++;
        $display("FAIL press k=%0d got=%b exp=%b", k, strobe_out, exp);
      end
    end
    idle(10);
  endtask

  task automatic test_glitch();
    logic [STB_N-1:0] exp;
    logic [6:0] pat;
    pat = 7'b1110111;  // bit k drives cycle k
    for (int k = 0; k < 16; k++) begin
      btn_in = (k < 7 && pat[k]) ? 2'b10 : 2'b00;
      tick();
      exp = (!DEB_ON && (k == 2 || k == 6)) ? 2'b10 : 2'b00;
      checks++;
      if (strobe_out !== exp) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b exp=%b", k, strobe_out, exp);
      end
    end
    idle(10);
  endtask

  task automatic test_simultaneous();
    logic [STB_N-1:0] exp;
    btn_in = 2'b11;
    for (int k = 0; k < 14; k++) begin
      if (k == 12) btn_in = 2'b00;
      tick();
      exp = (k == LAT) ? 2'b11 : 2'b00;
      checks++;
      if (strobe_out !== exp) begin
        errors++;
        $display("FAIL simultaneous k=%0d got=%b exp=%b", k, strobe_out, exp);
      end
    end
    idle(10);
  endtask

  task automatic test_reset_mid();
    logic [STB_N-1:0] exp;
    btn_in = 2'b01;
    for (int k = 0; k < 16; k++) begin
      rst = (k == 3);
      tick();
      exp = ((k == LAT && LAT < 3) || k == 4 + LAT) ? 2'b01 : 2'b00;
      checks++;
      if (strobe_out !== exp) begin
        errors++;
        $display("FAIL reset_mid k=%0d got=%b exp=%b", k, strobe_out, exp);
      end
    end
    rst = 1'b0;
    idle(10);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
